// File: rtl/vdp_timing_pkg.sv
// ---------------------------------------------------------------------------
// vdp_timing_pkg
// Horizontal timing constants shared by the VDP counter blocks.
//   hmode_t      line mode (H32 / H40)
//   DEF_*        default jump, sync and blank positions in Hcnt units
//   hmode_sel()  mode requested by the register bits (H40 needs mode 5)
// ---------------------------------------------------------------------------
package vdp_timing_pkg;

    typedef enum logic {
        HM_H32 = 1'b0,
        HM_H40 = 1'b1
    } hmode_t;

    localparam logic [8:0] HCNT_LAST = 9'h1FF;

    localparam logic [8:0] DEF_H32_JUMP_FROM = 9'h127;
    localparam logic [8:0] DEF_H32_JUMP_TO   = 9'h1D2;
    localparam logic [8:0] DEF_H40_JUMP_FROM = 9'h16C;
    localparam logic [8:0] DEF_H40_JUMP_TO   = 9'h1C9;

    localparam logic [8:0] DEF_H32_HS_START  = 9'h1D9;
    localparam logic [8:0] DEF_H32_HS_END    = 9'h1F2;
    localparam logic [8:0] DEF_H40_HS_START  = 9'h1CD;
    localparam logic [8:0] DEF_H40_HS_END    = 9'h1EC;

    localparam logic [8:0] DEF_H32_HB_START  = 9'h126;
    localparam logic [8:0] DEF_H40_HB_START  = 9'h166;
    localparam logic [8:0] DEF_HB_END        = 9'h00A;

    function automatic hmode_t hmode_sel(input logic h40, input logic m5);
        return (h40 & m5) ? HM_H40 : HM_H32;
    endfunction

endpackage

// File: rtl/vdp_sync2.sv
// ---------------------------------------------------------------------------
// vdp_sync2
// Two-flop synchroniser for an asynchronous level into the clk domain.
//   clk  in  sampling clock
//   rst  in  asynchronous reset, active high (both flops clear to 0)
//   d    in  asynchronous input
//   q    out synchronised level, two clk edges behind d
// ---------------------------------------------------------------------------
module vdp_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vdp_hcounter.sv
// ---------------------------------------------------------------------------
// vdp_hcounter
// 9-bit horizontal pixel counter for the VDP, feeding the H PLA decoder.
//   CLK      in   master clock
//   RES      in   asynchronous reset, active high
//   DCLK_EN  in   pixel-clock enable (counter advances only when high)
//   H40      in   register mode bit, 1 = H40
//   M5       in   mode 5 enable; 0 forces H32 timing
//   HL       in   asynchronous HV-latch request, rising edge active
//   HL_CLR   in   one-CLK latch clear (HV read / unlatch)
//   Hcnt     out  horizontal count
//   H40_LINE out  mode in effect for the current line
//   LINE_END out  one-CLK pulse after the enabled 0x1FF->0x000 edge
//   HSYNC_n  out  horizontal sync, active low
//   HBLANK   out  horizontal blank
//   HV_H     out  latched Hcnt[8:1]
//   HL_VALID out  HV_H holds a captured value
// ---------------------------------------------------------------------------
module vdp_hcounter
    import vdp_timing_pkg::*;
#(
    parameter logic [8:0] H32_JUMP_FROM = DEF_H32_JUMP_FROM,
    parameter logic [8:0] H32_JUMP_TO   = DEF_H32_JUMP_TO,
    parameter logic [8:0] H40_JUMP_FROM = DEF_H40_JUMP_FROM,
    parameter logic [8:0] H40_JUMP_TO   = DEF_H40_JUMP_TO,
    parameter logic [8:0] H32_HS_START  = DEF_H32_HS_START,
    parameter logic [8:0] H32_HS_END    = DEF_H32_HS_END,
    parameter logic [8:0] H40_HS_START  = DEF_H40_HS_START,
    parameter logic [8:0] H40_HS_END    = DEF_H40_HS_END,
    parameter logic [8:0] H32_HB_START  = DEF_H32_HB_START,
    parameter logic [8:0] H40_HB_START  = DEF_H40_HB_START,
    parameter logic [8:0] HB_END        = DEF_HB_END
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       DCLK_EN,
    input  logic       H40,
    input  logic       M5,
    input  logic       HL,
    input  logic       HL_CLR,
    output logic [8:0] Hcnt,
    output logic       H40_LINE,
    output logic       LINE_END,
    output logic       HSYNC_n,
    output logic       HBLANK,
    output logic [7:0] HV_H,
    output logic       HL_VALID
);

    // ------------------------------------------------------------------
    // Counter and line-mode next state
    // ------------------------------------------------------------------
    hmode_t     line_mode;
    hmode_t     mode_next;
    hmode_t     mode_eff;
    logic       wrap;
    logic [8:0] jump_from;
    logic [8:0] jump_to;
    logic [8:0] hcnt_next;
    logic [8:0] hs_start;
    logic [8:0] hs_end;
    logic [8:0] hb_start;
    logic       hsync_n_next;
    logic       hblank_next;

    always_comb begin
        mode_next = hmode_sel(H40, M5);
        wrap      = (Hcnt == HCNT_LAST);

        if (line_mode == HM_H40) begin
            jump_from = H40_JUMP_FROM;
            jump_to   = H40_JUMP_TO;
        end else begin
            jump_from = H32_JUMP_FROM;
            jump_to   = H32_JUMP_TO;
        end

        if (Hcnt == jump_from) begin
            hcnt_next = jump_to;
        end else begin
            hcnt_next = Hcnt + 9'd1;
        end

        // Sync/blank are decoded from the count being loaded, under the
        // mode that count belongs to: the new line's mode on the wrap edge.
        mode_eff = wrap ? mode_next : line_mode;

        if (mode_eff == HM_H40) begin
            hs_start = H40_HS_START;
            hs_end   = H40_HS_END;
            hb_start = H40_HB_START;
        end else begin
            hs_start = H32_HS_START;
            hs_end   = H32_HS_END;
            hb_start = H32_HB_START;
        end

        hsync_n_next = !((hcnt_next >= hs_start) && (hcnt_next < hs_end));
        hblank_next  = (hcnt_next >= hb_start) || (hcnt_next < HB_END);
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            Hcnt      <= '0;
            line_mode <= HM_H32;
            LINE_END  <= 1'b0;
            HSYNC_n   <= 1'b1;
            HBLANK    <= 1'b1;
        end else if (DCLK_EN) begin
            Hcnt      <= hcnt_next;
            line_mode <= mode_eff;
            LINE_END  <= wrap;
            HSYNC_n   <= hsync_n_next;
            HBLANK    <= hblank_next;
        end else begin
            LINE_END  <= 1'b0;
        end
    end

    assign H40_LINE = (line_mode == HM_H40);

    // ------------------------------------------------------------------
    // HV latch: HL synchronised, rising edge detected on the synced level
    // ------------------------------------------------------------------
    logic hl_sync;
    logic hl_prev;
    logic hl_rise;
    logic hl_capture;

    vdp_sync2 u_hl_sync (
        .clk (CLK),
        .rst (RES),
        .d   (HL),
        .q   (hl_sync)
    );

    // A clear in the same cycle re-arms the latch, so the edge is taken.
    assign hl_rise    = hl_sync & ~hl_prev;
    assign hl_capture = hl_rise & (~HL_VALID | HL_CLR);

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            hl_prev  <= 1'b0;
            HV_H     <= '0;
            HL_VALID <= 1'b0;
        end else begin
            hl_prev <= hl_sync;
            if (hl_capture) begin
                HV_H     <= Hcnt[8:1];
                HL_VALID <= 1'b1;
            end else if (HL_CLR) begin
                HL_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vdp_hcounter.sv
// ---------------------------------------------------------------------------
// tb_vdp_hcounter
// Bench for vdp_hcounter: a line-position model (pixel index within the
// line, mapped to Hcnt arithmetically) plus an HL sample history, compared
// against the DUT every cycle, and directed literal checks on line lengths,
// jump points, sync width, latch capture and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_vdp_hcounter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dclk_en = 1'b0;
    logic       h40 = 1'b0;
    logic       m5 = 1'b0;
    logic       hl = 1'b0;
    logic       hl_clr = 1'b0;
    logic [8:0] hcnt;
    logic       h40_line;
    logic       line_end;
    logic       hsync_n;
    logic       hblank;
    logic [7:0] hv_h;
    logic       hl_valid;

    always #5 clk = ~clk;

    vdp_hcounter dut (
        .CLK      (clk),
        .RES      (rst),
        .DCLK_EN  (dclk_en),
        .H40      (h40),
        .M5       (m5),
        .HL       (hl),
        .HL_CLR   (hl_clr),
        .Hcnt     (hcnt),
        .H40_LINE (h40_line),
        .LINE_END (line_end),
        .HSYNC_n  (hsync_n),
        .HBLANK   (hblank),
        .HV_H     (hv_h),
        .HL_VALID (hl_valid)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: position p within the line, 0..len-1
    // ------------------------------------------------------------------
    int       m_p = 0;
    bit       m_mode = 1'b0;
    bit       m_le = 1'b0;
    bit [7:0] m_hv = '0;
    bit       m_valid = 1'b0;
    bit [3:0] m_hist = '0;

    function automatic int line_len(input bit mode);
        return mode ? 420 : 342;
    endfunction

    // Active part runs straight from 0, then the tail is the top of the
    // 9-bit range ending at 0x1FF.
    function automatic int hc_of(input int p, input bit mode);
        int act;
        act = mode ? 365 : 296;
        if (p < act) return p;
        return 512 - (line_len(mode) - p);
    endfunction

    function automatic bit exp_hsync_n(input int h, input bit mode);
        if (mode) return !(h >= 'h1CD && h < 'h1EC);
        return !(h >= 'h1D9 && h < 'h1F2);
    endfunction

    function automatic bit exp_hblank(input int h, input bit mode);
        return (h >= (mode ? 'h166 : 'h126)) || (h < 'h00A);
    endfunction

    initial begin : model
        int cur;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_p = 0; m_mode = 1'b0; m_le = 1'b0;
                m_hv = '0; m_valid = 1'b0; m_hist = '0;
            end else begin
                cur = hc_of(m_p, m_mode);
                // m_hist[k] = HL as sampled k edges ago (k=0: this edge)
                m_hist = {m_hist[2:0], hl};
                if (m_hist[2] && !m_hist[3] && (!m_valid || hl_clr)) begin
                    m_hv = 8'(cur >> 1);
                    m_valid = 1'b1;
                end else if (hl_clr) begin
                    m_valid = 1'b0;
                end
                m_le = 1'b0;
                if (dclk_en) begin
                    if (m_p == line_len(m_mode) - 1) begin
                        m_p = 0;
                        m_mode = h40 & m5;
                        m_le = 1'b1;
                    end else begin
                        m_p++;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process plus line measurements for the directed checks
    // ------------------------------------------------------------------
    int         since = 0, period = 0, hs_acc = 0, hs_low = 0, jump_from = 0;
    logic [8:0] prev_h = '0;

    initial begin : compare
        int h;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                h = hc_of(m_p, m_mode);
                chk("hcnt", int'(hcnt), h);
                chk("h40_line", int'(h40_line), int'(m_mode));
                chk("line_end", int'(line_end), int'(m_le));
                chk("hsync_n", int'(hsync_n), int'(exp_hsync_n(h, m_mode)));
                chk("hblank", int'(hblank), int'(exp_hblank(h, m_mode)));
                chk("hv_h", int'(hv_h), int'(m_hv));
                chk("hl_valid", int'(hl_valid), int'(m_valid));
            end
            if (rst) begin
                since = 0; hs_acc = 0; prev_h = '0;
            end else begin
                since++;
                if (!hsync_n) hs_acc++;
                if (hcnt != prev_h && hcnt != 9'(prev_h + 9'd1)) jump_from = int'(prev_h);
                prev_h = hcnt;
                if (line_end) begin
                    period = since; hs_low = hs_acc; since = 0; hs_acc = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int phase = 0;
    int en_mode = 0;   // 0: always enabled, 1: every 4th CLK, 2: random
    bit rnd = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        phase++;
        case (en_mode)
            0:       dclk_en = 1'b1;
            1:       dclk_en = (phase % 4 == 0);
            default: dclk_en = ($urandom % 3 != 0);
        endcase
        if (rnd) begin
            if ($urandom % 8 == 0) hl = ~hl;
            hl_clr = ($urandom % 12 == 0);
            if ($urandom % 64 == 0) begin
                h40 = 1'($urandom);
                m5  = 1'($urandom);
            end
            rst = ($urandom % 1500 == 0);
        end
    endtask

    task automatic wait_le(input int maxc, input string what);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            tick();
            #5;
            if (line_end) seen = 1'b1;
        end
        if (!seen) chk({what, "_timeout"}, 0, 1);
    endtask

    task automatic wait_hcnt(input logic [8:0] val, input int maxc, input string what);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            tick();
            #5;
            if (hcnt == val) seen = 1'b1;
        end
        if (!seen) chk({what, "_timeout"}, 0, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin : stim
        // Reset state
        #2 rst = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("rst_hcnt", int'(hcnt), 0);
        chk("rst_h40_line", int'(h40_line), 0);
        chk("rst_line_end", int'(line_end), 0);
        chk("rst_hsync_n", int'(hsync_n), 1);
        chk("rst_hblank", int'(hblank), 1);
        chk("rst_hv_h", int'(hv_h), 0);
        chk("rst_hl_valid", int'(hl_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; m5 = 1'b1; h40 = 1'b0; dclk_en = 1'b1;

        // H32 lines
        wait_le(600, "t1_le0");
        wait_le(600, "t1_le1");
        chk("t1_period", period, 342);
        chk("t1_hs_low", hs_low, 25);
        chk("t1_jump", jump_from, 'h127);
        wait_hcnt(9'h009, 600, "t1_h009");
        chk("t1_hblank_009", int'(hblank), 1);
        tick(); #5;
        chk("t1_hblank_00a", int'(hblank), 0);
        wait_hcnt(9'h125, 600, "t1_h125");
        chk("t1_hblank_125", int'(hblank), 0);
        tick(); #5;
        chk("t1_hblank_126", int'(hblank), 1);

        // H40 requested from reset: first line H32, next H40
        rst = 1'b1; h40 = 1'b1;
        tick();
        rst = 1'b0;
        wait_le(600, "t2_le0");
        chk("t2_first_jump", jump_from, 'h127);
        chk("t2_h40_line", int'(h40_line), 1);
        wait_le(600, "t2_le1");
        chk("t2_period", period, 420);
        chk("t2_hs_low", hs_low, 31);
        chk("t2_jump", jump_from, 'h16C);

        // Mid-line mode change takes effect only at the next line
        wait_hcnt(9'h150, 600, "t3_h150");
        h40 = 1'b0;
        wait_le(600, "t3_le0");
        chk("t3_jump_h40", jump_from, 'h16C);
        chk("t3_period_h40", period, 420);
        chk("t3_h40_line", int'(h40_line), 0);
        wait_le(600, "t3_le1");
        chk("t3_jump_h32", jump_from, 'h127);
        chk("t3_period_h32", period, 342);

        // M5=0 forces H32; enable every 4th CLK
        m5 = 1'b0; h40 = 1'b1; en_mode = 1;
        wait_le(2000, "t4_le0");
        wait_le(2000, "t4_le1");
        chk("t4_period", period, 1368);
        chk("t4_hs_low", hs_low, 100);
        chk("t4_jump", jump_from, 'h127);
        chk("t4_h40_line", int'(h40_line), 0);

        // HV latch
        en_mode = 0; m5 = 1'b1; h40 = 1'b0; hl = 1'b0; hl_clr = 1'b1;
        tick();
        hl_clr = 1'b0;
        wait_hcnt(9'h0A5, 800, "t5_h0a5");
        hl = 1'b1;
        repeat (3) tick();
        #5;
        chk("t5_hv_h", int'(hv_h), 'h53);
        chk("t5_hl_valid", int'(hl_valid), 1);
        hl = 1'b0;
        repeat (4) tick();
        hl = 1'b1;
        repeat (5) tick();
        #5;
        chk("t5_hv_h_held", int'(hv_h), 'h53);
        hl_clr = 1'b1;
        tick();
        hl_clr = 1'b0;
        #5;
        chk("t5_clr_valid", int'(hl_valid), 0);
        chk("t5_clr_hv_h", int'(hv_h), 'h53);
        hl = 1'b0;
        repeat (4) tick();
        hl = 1'b1;
        repeat (2) tick();
        hl_clr = 1'b1;
        tick();
        hl_clr = 1'b0;
        #5;
        chk("t5_coincident_valid", int'(hl_valid), 1);

        // Asynchronous reset mid-sync
        wait_hcnt(9'h1E0, 800, "t6_h1e0");
        chk("t6_pre_hsync_n", int'(hsync_n), 0);
        #2 rst = 1'b1;
        #1;
        chk("t6_hcnt", int'(hcnt), 0);
        chk("t6_hsync_n", int'(hsync_n), 1);
        chk("t6_hblank", int'(hblank), 1);
        chk("t6_hl_valid", int'(hl_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0; hl = 1'b0;

        // Randomised run against the model
        rnd = 1'b1; en_mode = 2;
        repeat (6000) tick();
        rnd = 1'b0; en_mode = 0; rst = 1'b0; hl_clr = 1'b0; m5 = 1'b1; h40 = 1'b1;
        repeat (1000) tick();

        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
